// File: rtl/comp_status_reporter.sv
// Comparator-side status reporter: buffers {task, collision} results and replays them to the CSR block
// over a four-phase write/ack handshake. Optional ack watchdog enabled by `define COMP_STATUS_TIMEOUT_EN.
module comp_status_reporter #(
  parameter int KEY_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          result_valid,
  output logic                          result_ready,
  input  logic [KEY_WIDTH-1:0]          result_task,
  input  logic                          result_collision,
  output logic                          comp_status_write,
  input  logic                          comp_status_ack,
  output logic [KEY_WIDTH-1:0]          comp_current_task,
  output logic                          comp_collision_detected,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  input  logic                          sticky_clear,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic                 collision;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_LOW
  } state_t;

  entry_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [7:0]           drop_q;
  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [KEY_WIDTH-1:0] task_q, task_d;
  logic                 coll_q, coll_d;

  logic   full, push, pop, timeout_hit;
  entry_t head;

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  // A full FIFO refuses pushes even when the head retires in the same cycle.
  assign push = result_valid & ~full;
  assign head = mem_q[rd_ptr_q];

  // NOTE: storage needs no reset; the count/pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{key: result_task, collision: result_collision};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      task_q   <= '0;
      coll_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
      write_q <= write_d;
      task_q  <= task_d;
      coll_q  <= coll_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    task_d  = task_q;
    coll_d  = coll_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_REQ;
          write_d = 1'b1;
          task_d  = head.key;
          coll_d  = head.collision;
        end
      end
      ST_REQ: begin
        if (comp_status_ack) begin
          pop     = 1'b1;
          write_d = 1'b0;
          task_d  = '0;
          coll_d  = 1'b0;
          state_d = ST_WAIT_LOW;
        end else if (timeout_hit) begin
          pop     = 1'b1;
          write_d = 1'b0;
          task_d  = '0;
          coll_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!comp_status_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        task_d  = '0;
        coll_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (sticky_clear) begin
      drop_q <= '0;
    end else if (result_valid && full && drop_q != 8'hFF) begin
      drop_q <= drop_q + 1'b1;
    end
  end

`ifdef COMP_STATUS_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] timer_q;
  logic             timeout_err_q;

  // Timer reads 0 on the first REQ cycle, so the watchdog fires on the TIMEOUT_CYCLES-th cycle.
  assign timeout_hit = (state_q == ST_REQ) && !comp_status_ack &&
                       (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q <= (state_q == ST_REQ) ? timer_q + 1'b1 : '0;
      if (sticky_clear)     timeout_err_q <= 1'b0;
      else if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign result_ready            = ~full;
  assign comp_status_write       = write_q;
  assign comp_current_task       = task_q;
  assign comp_collision_detected = coll_q;
  assign fifo_count              = count_q;
  assign drop_count              = drop_q;

endmodule

// File: tb/tb_comp_status_reporter.sv
// Scoreboard bench for comp_status_reporter: stimulus queues expected requests, a negedge monitor checks them.
module tb_comp_status_reporter;

`ifdef COMP_STATUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] result_task;
  logic       result_collision;
  logic       comp_status_write;
  logic       comp_status_ack;
  logic [3:0] comp_current_task;
  logic       comp_collision_detected;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  logic       sticky_clear;
  logic       timeout_err;

  comp_status_reporter #(
    .KEY_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .result_valid           (result_valid),
    .result_ready           (result_ready),
    .result_task            (result_task),
    .result_collision       (result_collision),
    .comp_status_write      (comp_status_write),
    .comp_status_ack        (comp_status_ack),
    .comp_current_task      (comp_current_task),
    .comp_collision_detected(comp_collision_detected),
    .fifo_count             (fifo_count),
    .drop_count             (drop_count),
    .sticky_clear           (sticky_clear),
    .timeout_err            (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] key;
    logic       coll;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_write = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every new request must match the oldest expected entry and hold steady while write is high.
  always @(negedge clk) begin
    if (!reset) begin
      prev_write = 1'b0;
    end else begin
      if (comp_status_write && !prev_write) begin
        if (sb.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          check("req_task", comp_current_task, cur.key);
          check("req_coll", comp_collision_detected, cur.coll);
        end
      end else if (comp_status_write) begin
        check("hold_task", comp_current_task, cur.key);
      end
      prev_write = comp_status_write;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] k, input logic c, input bit accept);
    result_valid     = 1'b1;
    result_task      = k;
    result_collision = c;
    if (accept) sb.push_back('{key: k, coll: c});
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!comp_status_write && n < 100) begin
      tick();
      n++;
    end
    if (!comp_status_write) check("req_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic serve(input int delay);
    wait_req();
    repeat (delay) tick();
    comp_status_ack = 1'b1;
    tick();
    comp_status_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int n;
    reset            = 1'b0;
    result_valid     = 1'b0;
    result_task      = '0;
    result_collision = 1'b0;
    comp_status_ack  = 1'b0;
    sticky_clear     = 1'b0;

    #12;
    check("rst_write", comp_status_write, 0);
    check("rst_task",  comp_current_task, 0);
    check("rst_coll",  comp_collision_detected, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop",  drop_count, 0);
    check("rst_ready", result_ready, 1);
    check("rst_err",   timeout_err, 0);
    #11 reset = 1'b1;
    tick();

    // Single result, one-cycle ack.
    push(4'd2, 1'b0, 1'b1);
    check("t1_count_push", fifo_count, 1);
    check("t1_write_lat",  comp_status_write, 0);
    tick();
    check("t1_write",      comp_status_write, 1);
    check("t1_task",       comp_current_task, 2);
    check("t1_coll",       comp_collision_detected, 0);
    comp_status_ack = 1'b1;
    tick();
    comp_status_ack = 1'b0;
    check("t1_write_fall", comp_status_write, 0);
    check("t1_task_clr",   comp_current_task, 0);
    check("t1_count_pop",  fifo_count, 0);
    tick();
    tick();
    check("t1_idle",       comp_status_write, 0);

    // Back-to-back burst with slow acks.
    push(4'd3, 1'b0, 1'b1);
    push(4'd4, 1'b1, 1'b1);
    push(4'd5, 1'b1, 1'b1);
    push(4'd6, 1'b0, 1'b1);
    check("t2_ready", result_ready, 0);
    check("t2_count", fifo_count, 4);
    check("t2_drop",  drop_count, 0);
    repeat (4) serve(5);
    tick();
    tick();
    check("t2_count_end", fifo_count, 0);
    check("t2_ready_end", result_ready, 1);

    // Overflow while ack is held low.
    push(4'd10, 1'b0, 1'b1);
    push(4'd11, 1'b1, 1'b1);
    push(4'd12, 1'b0, 1'b1);
    push(4'd13, 1'b1, 1'b1);
    check("t3_ready_full", result_ready, 0);
    push(4'd14, 1'b1, 1'b0);
    push(4'd15, 1'b0, 1'b0);
    check("t3_count", fifo_count, 4);
    check("t3_drop",  drop_count, 2);
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    check("t3_drop_clr", drop_count, 0);
    repeat (4) serve(0);
    tick();
    tick();

    // Push in the same cycle the head is acknowledged.
    push(4'd8, 1'b1, 1'b1);
    push(4'd1, 1'b0, 1'b1);
    wait_req();
    check("t4_count_pre", fifo_count, 2);
    comp_status_ack  = 1'b1;
    result_valid     = 1'b1;
    result_task      = 4'd7;
    result_collision = 1'b1;
    sb.push_back('{key: 4'd7, coll: 1'b1});
    tick();
    comp_status_ack = 1'b0;
    result_valid    = 1'b0;
    check("t4_count_same", fifo_count, 2);
    serve(0);
    serve(0);
    tick();
    tick();
    check("t4_count_end", fifo_count, 0);

    // Reset asserted mid-request, ack high afterwards.
    push(4'd3, 1'b0, 1'b1);
    push(4'd4, 1'b1, 1'b1);
    push(4'd6, 1'b1, 1'b1);
    wait_req();
    check("t5_count_pre", fifo_count, 3);
    #1 reset = 1'b0;
    #1;
    check("t5_write", comp_status_write, 0);
    check("t5_count", fifo_count, 0);
    check("t5_ready", result_ready, 1);
    check("t5_task",  comp_current_task, 0);
    sb.delete();
    comp_status_ack = 1'b1;
    #10 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_no_req", comp_status_write, 0);
    end
    comp_status_ack = 1'b0;
    tick();

`ifdef COMP_STATUS_TIMEOUT_EN
    // Ack watchdog: task 9 is never acknowledged.
    push(4'd9, 1'b1, 1'b1);
    push(4'd5, 1'b0, 1'b1);
    wait_req();
    n = 0;
    while (comp_status_write && n < 20) begin
      n++;
      tick();
    end
    check("t6_req_cycles", n, 8);
    check("t6_err",        timeout_err, 1);
    check("t6_count",      fifo_count, 1);
    serve(0);
    tick();
    tick();
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    check("t6_err_clr", timeout_err, 0);
`else
    n = 0;
    check("t6_err_tied", timeout_err, 0);
`endif

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_status_reporter.md
Name: comp_status_reporter

Overview:
- Comparator-side initiator for the status-write handshake into the CSR register block.
- Buffers comparison results (task key and collision flag) from the fingerprint comparator in a small FIFO.
- Presents results one at a time on comp_status_write / comp_current_task / comp_collision_detected and retires each on comp_status_ack.
- Decouples comparator throughput from CSR-side arbitration stalls while the CPU is accessing the CSR block.

Parameters:
- KEY_WIDTH, 4, width of task key; equals CRC_KEY_WIDTH.
- FIFO_DEPTH, 4, result entries buffered; power of two, at least 2.
- TIMEOUT_CYCLES, 64, ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset reset, asynchronous, active-low.
- result_valid  in  1  comparator offers a result this cycle.
- result_ready  out  1  FIFO can accept; equals !full.
- result_task  in  KEY_WIDTH  task key of offered result.
- result_collision  in  1  1 = fingerprint mismatch (fail), 0 = match (success).
- comp_status_write  out  1  request to CSR block; registered.
- comp_status_ack  in  1  CSR block acknowledge (level).
- comp_current_task  out  KEY_WIDTH  task key of current request; registered.
- comp_collision_detected  out  1  collision flag of current request; registered.
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held, including the entry being presented.
- drop_count  out  8  results lost because the FIFO was full; saturates at 255.
- sticky_clear  in  1  synchronous clear of drop_count and timeout_err.
- timeout_err  out  1  sticky ack-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empties; state goes to IDLE.
  - All outputs go to 0, except result_ready, which goes to 1.
- Push: result_valid & result_ready at a rising edge writes {task, collision} at the tail.
- Drop: result_valid & !result_ready increments drop_count (saturating) and discards the result.
- No push is accepted when the FIFO is full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: write=0. If the FIFO is non-empty, go to REQ at the next edge and load the registered outputs from the FIFO head. Minimum latency is one cycle from push into an empty FIFO to comp_status_write=1.
  - REQ: write=1, with task and collision held stable. When ack=1 is sampled, pop the head, drive write=0 and the data outputs to 0 at the same edge, and go to WAIT_LOW.
  - WAIT_LOW: write=0. When ack=0 is sampled, go to IDLE. A queued entry is therefore re-requested two cycles after ack falls, which gives a four-phase handshake.
- An ack received while in IDLE is ignored.
- If ack is already high on entry to REQ, it is honoured at the next edge (one-cycle request).
- fifo_count updates in the same cycle as a push or pop. Simultaneous push and pop leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Entries are presented in strict FIFO order.
- sticky_clear has priority over an increment in the same cycle; the result is 0.
- Reset asserted mid-handshake:
  - Outputs drop to 0 immediately and queued results are lost.
  - After reset, a high ack is ignored until REQ is reached.

Optional Feature:
- Macro: COMP_STATUS_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to REQ and increments each cycle spent in REQ.
  - When it reaches TIMEOUT_CYCLES with no ack, the block pops and discards the head, sets timeout_err, drives write=0, and goes to IDLE.
  - timeout_err is cleared only by sticky_clear or reset.
- Without the macro:
  - REQ waits indefinitely.
  - timeout_err is tied to 0 and no counter logic is generated.

Test Plan:
- Single result: push task 2, collision 0 into an empty FIFO. Expect write=1 with task=2 and collision=0 on the next edge. ack held high for 1 cycle: write falls at the same edge. ack low: return to IDLE; fifo_count goes 1→0.
- Back-to-back burst: push tasks 3,4,5,6 with collisions 0,1,1,0 on consecutive cycles, with ack delayed 5 cycles per request. Expect the requests in order 3,4,5,6 with matching flags. result_ready=0 after the fourth push; drop_count=0.
- Overflow: hold ack low and push 6 results. Expect fifo_count=4, drop_count=2, and result_ready=0 after the fourth push. sticky_clear → drop_count=0.
- Simultaneous push and pop: FIFO holds 2 entries; push task 7 in the same cycle ack is sampled in REQ. Expect fifo_count to remain 2 and task 7 to be presented last.
- Reset mid-request: in REQ with 3 entries queued, pulse reset low. Expect write=0, fifo_count=0, result_ready=1 asynchronously, and no request while ack stays high afterwards.
- With COMP_STATUS_TIMEOUT_EN and TIMEOUT_CYCLES=8: never ack task 9. Expect write to drop after 8 cycles in REQ, timeout_err=1, and the next queued task to be presented afterwards.
